// File: rtl/ob.sv
// rtl/ob.sv - switch output port: arbiter, crossbar slice, output FIFO, link driver.
// Define OB_RR_EN for round-robin arbitration; fixed lowest-index priority otherwise.
module ob #(
    parameter int NPORT = 4,
    parameter int PKTW  = 17,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NPORT*(PKTW+1)-1:0] pkti,
    input  logic [NPORT-1:0]          req,
    output logic [NPORT-1:0]          ack,
    output logic [PKTW:0]             pkto,
    input  logic                      full
);
    localparam int W  = PKTW + 1;
    localparam int GW = $clog2(NPORT);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   gnt_q, gnt_d, win;
    logic [W-1:0]    mem_q [DEPTH];
    logic [AW-1:0]   wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    pkto_q, pkto_d, cur;
    logic            grant_on, push, pop, tail;
`ifdef OB_RR_EN
    logic [GW-1:0]   rr_q, rr_d;
`endif

    // ack depends only on registered state so it never combinationally follows req/pkti/full
    assign cur      = pkti[gnt_q*W +: W];
    assign grant_on = (state_q == GRANT) && (cnt_q < CW'(DEPTH));
    assign push     = grant_on && (cur[PKTW:PKTW-1] != 2'b00);
    assign tail     = grant_on && (cur[PKTW:PKTW-1] == 2'b11);
    assign pop      = !full && (cnt_q != '0);
    assign pkto     = pkto_q;

    always_comb begin
        ack = '0;
        if (grant_on) ack[gnt_q] = 1'b1;
    end

`ifdef OB_RR_EN
    // scan downward so the last hit is the first requester at or after rr
    always_comb begin
        win = '0;
        for (int k = NPORT - 1; k >= 0; k--) begin
            if (req[(int'(rr_q) + k) % NPORT]) win = GW'((int'(rr_q) + k) % NPORT);
        end
    end
`else
    always_comb begin
        win = '0;
        for (int k = NPORT - 1; k >= 0; k--) begin
            if (req[k]) win = GW'(k);
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
`ifdef OB_RR_EN
        rr_d    = rr_q;
`endif
        if (state_q == IDLE) begin
            if (|req) begin
                gnt_d   = win;
                state_d = GRANT;
            end
        end else if (tail) begin
            state_d = IDLE;
`ifdef OB_RR_EN
            rr_d    = (gnt_q == GW'(NPORT - 1)) ? '0 : gnt_q + 1'b1;
`endif
        end
    end

    always_comb begin
        wp_d   = push ? wp_q + 1'b1 : wp_q;
        rp_d   = pop  ? rp_q + 1'b1 : rp_q;
        pkto_d = pop  ? mem_q[rp_q] : '0;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            pkto_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
            pkto_q  <= pkto_d;
        end
    end

`ifdef OB_RR_EN
    always_ff @(posedge clk) begin
        if (rst) rr_q <= '0;
        else     rr_q <= rr_d;
    end
`endif

    // storage needs no reset: pointers and count define what is valid
    always_ff @(posedge clk) begin
        if (push) mem_q[wp_q] <= cur;
    end
endmodule

// File: tb/tb_ob.sv
// tb/tb_ob.sv - randomized self-checking bench for ob against a queue-based reference model.
module tb_ob;
    localparam int NPORT = 4;
    localparam int PKTW  = 17;
    localparam int DEPTH = 4;
    localparam int W     = PKTW + 1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NPORT*W-1:0]    pkti;
    logic [NPORT-1:0]      req;
    logic [NPORT-1:0]      ack;
    logic [PKTW:0]         pkto;
    logic                  full;

    ob #(.NPORT(NPORT), .PKTW(PKTW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .pkti(pkti), .req(req),
        .ack(ack), .pkto(pkto), .full(full)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int full_mode = 0;

    // per-input packet sources and the reference model state
    logic [W-1:0] in_q [NPORT][$];
    logic [W-1:0] m_fifo [$];
    bit           m_busy = 0;
    int           m_gnt  = 0;
    int           m_rr   = 0;
    logic [W-1:0] m_pkto = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NPORT-1:0] model_ack();
        logic [NPORT-1:0] a = '0;
        if (m_busy && m_fifo.size() < DEPTH) a[m_gnt] = 1'b1;
        return a;
    endfunction

    function automatic bit pending();
        bit p = 0;
        for (int i = 0; i < NPORT; i++) if (in_q[i].size() != 0) p = 1;
        return p || m_busy || (m_fifo.size() != 0);
    endfunction

    task automatic add_pkt(input int p, input int nbody, input bit idles);
        in_q[p].push_back({2'b01, 16'($urandom)});
        for (int b = 0; b < nbody; b++) begin
            if (idles) in_q[p].push_back({2'b00, 16'($urandom)});
            in_q[p].push_back({2'b10, 16'($urandom)});
        end
        in_q[p].push_back({2'b11, 16'($urandom)});
    endtask

    task automatic step();
        logic [NPORT-1:0] a;
        logic [W-1:0]     f;
        int               win;
        @(negedge clk);
        a = model_ack();
        check("ack", 32'(ack), 32'(a));
        check("pkto", 32'(pkto), 32'(m_pkto));
        for (int i = 0; i < NPORT; i++) begin
            f = (in_q[i].size() != 0) ? in_q[i][0] : '0;
            pkti[i*W +: W] = f;
            // sources may drop req once past their head flit
            req[i] = (in_q[i].size() != 0) && !(f[W-1:W-2] != 2'b01 && $urandom_range(3) == 0);
        end
        full = (full_mode == 1) || (full_mode == 2 && $urandom_range(2) == 0);
        if (rst) begin
            m_busy = 0; m_gnt = 0; m_rr = 0; m_pkto = '0;
            m_fifo.delete();
        end else begin
            if (!full && m_fifo.size() != 0) m_pkto = m_fifo.pop_front();
            else                             m_pkto = '0;
            if (a != '0) begin
                f = pkti[m_gnt*W +: W];
                if (in_q[m_gnt].size() != 0) void'(in_q[m_gnt].pop_front());
                if (f[W-1:W-2] != 2'b00) m_fifo.push_back(f);
                if (f[W-1:W-2] == 2'b11) begin
                    m_busy = 0;
                    m_rr   = (m_gnt + 1) % NPORT;
                end
            end else if (!m_busy && req != '0) begin
                win = -1;
`ifdef OB_RR_EN
                for (int k = 0; k < NPORT; k++)
                    if (win < 0 && req[(m_rr + k) % NPORT]) win = (m_rr + k) % NPORT;
`else
                for (int k = 0; k < NPORT; k++)
                    if (win < 0 && req[k]) win = k;
`endif
                m_gnt  = win;
                m_busy = 1;
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        full_mode = 0;
        while (pending() && n < 500) begin
            step();
            n++;
        end
        if (n >= 500) check("drain_timeout", 32'(n), 32'(0));
        step();
        step();
    endtask

    initial begin
        rst = 1'b1; req = '0; pkti = '0; full = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // single two-flit packet from input 1
        in_q[1].push_back({2'b01, 16'h1234});
        in_q[1].push_back({2'b11, 16'hABCD});
        drain();

        // all inputs competing, two packets each
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < NPORT; p++) add_pkt(p, 0, 0);
        drain();

        // backpressure during a 6-flit packet from input 2
        add_pkt(2, 4, 0);
        full_mode = 1;
        repeat (10) step();
        check("fifo_full_depth", 32'(m_fifo.size()), 32'(DEPTH));
        drain();

        // idle flits interleaved with body flits on input 3
        add_pkt(3, 4, 1);
        drain();

        // input 0 requests while input 3 is mid-packet
        add_pkt(3, 3, 0);
        step();
        step();
        add_pkt(0, 1, 0);
        drain();

        // reset with a partially buffered packet and an active grant
        add_pkt(1, 6, 0);
        full_mode = 1;
        repeat (5) step();
        rst = 1'b1;
        for (int i = 0; i < NPORT; i++) in_q[i].delete();
        step();
        rst = 1'b0;
        full_mode = 0;
        step();
        add_pkt(2, 1, 0);
        drain();

        // random traffic with random backpressure
        full_mode = 2;
        repeat (400) begin
            for (int p = 0; p < NPORT; p++)
                if (in_q[p].size() == 0 && $urandom_range(3) == 0)
                    add_pkt(p, $urandom_range(3), 1'($urandom_range(1)));
            step();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
